event_timestamp_fifo: RTL
=========================

Name: event_timestamp_fifo

Overview:
Parametrised, single-clock successor of the EVR event FIFO. It filters incoming event codes through a per-code enable mask and stamps each accepted code with the current seconds and event-clock timestamp. Entries go into an inferred-RAM first-word-fall-through FIFO of configurable depth. Overflow is reported and counted, interrupts fire on a fill threshold, and an external strobe latches the time.

Parameters:
DEPTH_LOG2, 9, FIFO depth = 2**DEPTH_LOG2 entries.
TS_WIDTH, 32, timestamp counter width.
SEC_WIDTH, 32, seconds register and shift register width.
IRQ_THRESHOLD, 1, entry count at or above which INTERRUPT_OUT asserts (1..2**DEPTH_LOG2).

Ports:
CLK_IN  in  1  event clock; the only clock.
RST_IN  in  1  asynchronous, active-high reset.
EVENT_CODE_IN  in  8  received event code, one per cycle.
MASK_WE_IN  in  1  mask write strobe.
MASK_ADDR_IN  in  8  event code whose enable bit is written.
MASK_DATA_IN  in  1  enable value to write.
POP_IN  in  1  consume the head entry.
VALID_OUT  in/out: out  1  head entry valid (equals ~EMPTY_OUT).
EVENT_CODE_OUT  out  8  head entry event code.
SECONDS_OUT  out  SEC_WIDTH  head entry seconds.
TIMESTAMP_OUT  out  TS_WIDTH  head entry timestamp.
COUNT_OUT  out  DEPTH_LOG2+1  entries held, including the head.
EMPTY_OUT  out  1  no entries.
FULL_OUT  out  1  COUNT_OUT == 2**DEPTH_LOG2.
OVERFLOW_OUT  out  1  sticky: an accepted code was dropped.
OVF_CLR_IN  in  1  clears OVERFLOW_OUT and DROP_COUNT_OUT.
DROP_COUNT_OUT  out  16  saturating count of dropped entries.
INTERRUPT_OUT  out  1  registered (COUNT_OUT >= IRQ_THRESHOLD) or OVERFLOW_OUT.
LATCH_IN  in  1  synchronous time-latch request; acts on its rising edge.
SECONDS_LATCH_OUT  out  SEC_WIDTH  seconds captured at the latch edge.
TIMESTAMP_LATCH_OUT  out  TS_WIDTH  timestamp captured at the latch edge.

Behaviour:
- Reset (asynchronous, active-high):
  - All counters, registers and outputs go to 0; EMPTY_OUT = 1.
  - The mask resets to all-enabled.
  - Codes 0x00 and 0xBC are never stored, whatever their mask bit.
- Timestamp counter:
  - Increments by 1 every cycle and wraps at 2**TS_WIDTH.
  - Code 0x7D sampled at edge k: counter = 0 after edge k, seconds register <= seconds shift register.
- Seconds shift register:
  - Code 0x70 shifts in 0 (LSB side); code 0x71 shifts in 1.
  - 0x70/0x71 are stored only if enabled in the mask.
- Entry capture:
  - Code C sampled at edge k with mask[C] = 1 forms the entry {C, seconds, timestamp}.
  - Seconds and timestamp are the values held before edge k, so a 0x7D entry carries the pre-reset timestamp.
  - Entry is pipeline-registered at edge k and written to RAM at edge k+1; COUNT_OUT increments at edge k+1.
  - Into an empty FIFO: VALID_OUT = 1 and head fields valid after edge k+2 (FWFT output register).
- Mask writes:
  - A write at edge k affects codes sampled from edge k+1 onward.
  - A code sampled in the same edge as a write to its own bit uses the old bit.
- Pop:
  - POP_IN with VALID_OUT = 1 advances the head.
  - The next entry, if present, appears after the following edge with no bubble.
  - POP_IN while empty is ignored and COUNT_OUT is unchanged.
- Full:
  - A write attempt while FULL_OUT = 1 and no pop in the same cycle drops the entry.
  - OVERFLOW_OUT is set and DROP_COUNT_OUT increments, saturating at 0xFFFF.
  - A write together with a pop in the same cycle while full is accepted; COUNT_OUT stays the same.
- OVF_CLR_IN:
  - Clears OVERFLOW_OUT and DROP_COUNT_OUT at the next edge.
  - If a drop happens in that same edge, set wins: OVERFLOW_OUT = 1, DROP_COUNT_OUT = 1.
- Latch: a rising edge of LATCH_IN (previous 0, now 1) at edge k captures the pre-edge seconds and timestamp into the latch outputs.
- INTERRUPT_OUT is registered: it follows COUNT_OUT / OVERFLOW_OUT by one cycle.
- Pointers are DEPTH_LOG2+1 bits, using the MSB-wrap scheme for full/empty. COUNT_OUT = wr_ptr - rd_ptr.

Test Plan:
- Reset then feed 0x01, 0x00, 0xBC, 0x02 on consecutive cycles -> exactly 2 entries (0x01, 0x02); first VALID_OUT 2 edges after 0x01 sampled; timestamps differ by 3.
- Shift 0x71, 0x70 ×30, 0x71 (32 codes), then 0x7D -> SECONDS_OUT of the next entry = 0x80000001; its timestamp equals the cycles elapsed since 0x7D was sampled.
- DEPTH_LOG2 = 4: push 18 enabled codes with no pops -> FULL_OUT = 1, COUNT_OUT = 16, DROP_COUNT_OUT = 2, OVERFLOW_OUT = 1, INTERRUPT_OUT = 1. Then OVF_CLR_IN -> both cleared.
- Full FIFO, POP_IN together with a new code -> COUNT_OUT stays 16, no drop, new code read out last.
- MASK_WE_IN addr 0x05 data 0 -> subsequent 0x05 not stored; 0x06 still stored; re-enabling restores storage.
- LATCH_IN held high 5 cycles after a 0x7D -> latch captures once at the rising edge only; TIMESTAMP_LATCH_OUT equals the counter value before that edge.

Source files
------------

// File: rtl/event_timestamp_fifo.sv
// Filters event codes through a per-code mask, stamps accepted codes with seconds/timestamp and queues
// them in a first-word-fall-through RAM FIFO; a code sampled at edge k is at the head after edge k+2.
module event_timestamp_fifo #(
  parameter int DEPTH_LOG2    = 9,
  parameter int TS_WIDTH      = 32,
  parameter int SEC_WIDTH     = 32,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  input  logic [7:0]            EVENT_CODE_IN,
  input  logic                  MASK_WE_IN,
  input  logic [7:0]            MASK_ADDR_IN,
  input  logic                  MASK_DATA_IN,
  input  logic                  POP_IN,
  output logic                  VALID_OUT,
  output logic [7:0]            EVENT_CODE_OUT,
  output logic [SEC_WIDTH-1:0]  SECONDS_OUT,
  output logic [TS_WIDTH-1:0]   TIMESTAMP_OUT,
  output logic [DEPTH_LOG2:0]   COUNT_OUT,
  output logic                  EMPTY_OUT,
  output logic                  FULL_OUT,
  output logic                  OVERFLOW_OUT,
  input  logic                  OVF_CLR_IN,
  output logic [15:0]           DROP_COUNT_OUT,
  output logic                  INTERRUPT_OUT,
  input  logic                  LATCH_IN,
  output logic [SEC_WIDTH-1:0]  SECONDS_LATCH_OUT,
  output logic [TS_WIDTH-1:0]   TIMESTAMP_LATCH_OUT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = 8 + SEC_WIDTH + TS_WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] IRQ_LVL  = (DEPTH_LOG2+1)'(IRQ_THRESHOLD);
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
  localparam logic [7:0] CODE_NULL = 8'h00;
  localparam logic [7:0] CODE_K28  = 8'hBC;
  localparam logic [7:0] CODE_SH0  = 8'h70;
  localparam logic [7:0] CODE_SH1  = 8'h71;
  localparam logic [7:0] CODE_TRST = 8'h7D;

  logic [255:0]          mask;
  logic [TS_WIDTH-1:0]   ts;
  logic [SEC_WIDTH-1:0]  sec;
  logic [SEC_WIDTH-1:0]  sec_shift;
  logic                  pipe_vld;
  logic [EW-1:0]         pipe_dat;
  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   count;
  logic                  head_vld;
  logic [EW-1:0]         head_dat;
  logic                  accept;
  logic                  full;
  logic                  pop_eff;
  logic                  wr_en;
  logic                  drop;
  logic                  ovf;
  logic [15:0]           drop_cnt;
  logic                  irq;
  logic                  latch_prev;
  logic [SEC_WIDTH-1:0]  sec_latch;
  logic [TS_WIDTH-1:0]   ts_latch;

  // Mask is read before this edge's write lands, so a same-cycle write to its own bit uses the old value.
  assign accept = mask[EVENT_CODE_IN] && (EVENT_CODE_IN != CODE_NULL) && (EVENT_CODE_IN != CODE_K28);

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_LVL);
  assign pop_eff    = POP_IN && head_vld;
  assign wr_en      = pipe_vld && (!full || pop_eff);
  assign drop       = pipe_vld && full && !pop_eff;
  assign rd_ptr_nxt = pop_eff ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ts        <= '0;
      sec       <= '0;
      sec_shift <= '0;
      mask      <= '1;
    end else begin
      if (EVENT_CODE_IN == CODE_TRST) begin
        ts  <= '0;
        sec <= sec_shift;
      end else begin
        ts <= ts + TS_ONE;
      end
      if (EVENT_CODE_IN == CODE_SH0 || EVENT_CODE_IN == CODE_SH1)
        sec_shift <= {sec_shift[SEC_WIDTH-2:0], EVENT_CODE_IN[0]};
      if (MASK_WE_IN)
        mask[MASK_ADDR_IN] <= MASK_DATA_IN;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pipe_vld <= 1'b0;
      pipe_dat <= '0;
    end else begin
      pipe_vld <= accept;
      pipe_dat <= {EVENT_CODE_IN, sec, ts};
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (wr_en)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= pipe_dat;
  end

  // Head register always prefetches the entry at the post-pop read pointer, giving no bubble on pop.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr   <= rd_ptr_nxt;
      head_vld <= (wr_ptr != rd_ptr_nxt);
      if (wr_ptr != rd_ptr_nxt)
        head_dat <= mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
      irq      <= 1'b0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
        if (OVF_CLR_IN)
          drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (OVF_CLR_IN) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
      irq <= (count >= IRQ_LVL) || ovf;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      latch_prev <= 1'b0;
      sec_latch  <= '0;
      ts_latch   <= '0;
    end else begin
      latch_prev <= LATCH_IN;
      if (LATCH_IN && !latch_prev) begin
        sec_latch <= sec;
        ts_latch  <= ts;
      end
    end
  end

  assign VALID_OUT           = head_vld;
  assign EMPTY_OUT           = !head_vld;
  assign EVENT_CODE_OUT      = head_dat[EW-1 -: 8];
  assign SECONDS_OUT         = head_dat[TS_WIDTH +: SEC_WIDTH];
  assign TIMESTAMP_OUT       = head_dat[TS_WIDTH-1:0];
  assign COUNT_OUT           = count;
  assign FULL_OUT            = full;
  assign OVERFLOW_OUT        = ovf;
  assign DROP_COUNT_OUT      = drop_cnt;
  assign INTERRUPT_OUT       = irq;
  assign SECONDS_LATCH_OUT   = sec_latch;
  assign TIMESTAMP_LATCH_OUT = ts_latch;

endmodule
